register_controller: RTL and testbench
======================================

Name: register_controller

Overview:
Sequences all access to the 8-entry general-purpose register file for the core. It accepts decoded operand-read requests, drives the file's get/set/reset controls, and returns operand pairs through a valid/ready handshake. It also owns the single write port for writeback and tracks a pending-write scoreboard so that reads of in-flight destinations stall (RAW interlock). Software/sequencer-initiated register clears are serialised through the same controller.

Parameters:
WORD_SIZE, 8, width of one register / data word (same value as the core-wide word size)
NUM_REGS, 8, number of general-purpose registers
REG_BITS, 3, register index width

Ports:
clock  in  1  core clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
rd_valid  in  1  operand-read request valid
rd_ready  out  1  controller accepts request this cycle
rd_src1  in  REG_BITS  first source index
rd_src2  in  REG_BITS  second source index
rd_dst  in  REG_BITS  destination the issuing instruction will write
rd_dst_en  in  1  1 = mark rd_dst pending on accept
op_valid  out  1  operand pair valid
op_ready  in  1  consumer takes operands
op_a  out  WORD_SIZE  value of rd_src1
op_b  out  WORD_SIZE  value of rd_src2
wb_valid  in  1  writeback request
wb_ready  out  1  writeback accepted this cycle
wb_num  in  REG_BITS  writeback register index
wb_val  in  WORD_SIZE  writeback data
clear_req  in  1  request zeroing of all registers (one-cycle pulse)
clear_done  out  1  one-cycle pulse: clear completed
busy  out  1  state != IDLE or any pending bit set
rf_num1, rf_num2  out  REG_BITS  register file read indices
rf_get_enable  out  1  register file get strobe
rf_set_enable  out  1  register file write strobe
rf_set_num  out  REG_BITS  register file write index
rf_set_val  out  WORD_SIZE  register file write data
rf_reset_enable  out  1  register file clear strobe
rf_out1, rf_out2  in  WORD_SIZE  register file outputs (registered; valid the cycle after get)

Behaviour:
- Reset: state=IDLE, pending[NUM_REGS-1:0]=0, clear_pend=0, op_valid=0, op_a=op_b=0, clear_done=0. All rf_* strobes 0 while reset is high. Reset does NOT clear register file contents.
- FSM states: IDLE, READ, HOLD, CLEAR.
- hazard = pending[rd_src1] | pending[rd_src2] | (wb_valid & (wb_num==rd_src1 | wb_num==rd_src2)).
- rd_ready = (state==IDLE) & ~clear_pend & ~clear_req & ~hazard. Combinational; rd_valid never gates rd_ready.
- Accept (rd_valid & rd_ready) at cycle T: rf_get_enable=1, rf_num1=rd_src1, rf_num2=rd_src2; if rd_dst_en then pending[rd_dst]<=1; state->READ.
- READ (T+1): op_a<=rf_out1, op_b<=rf_out2, op_valid<=1; state->HOLD.
- HOLD (from T+2): op_valid=1, op_a/op_b stable until op_ready; on op_ready: op_valid<=0, state->IDLE. Earliest next accept is the following cycle (max throughput: 1 read per 3 cycles).
- Writeback: wb_ready = (state!=CLEAR). On accept: rf_set_enable=1, rf_set_num=wb_num, rf_set_val=wb_val, pending[wb_num]<=0. Accepted in any other state, including concurrently with a read accept.
- Same-cycle read accept with rd_dst==wb_num and rd_dst_en: the pending set wins (bit ends at 1).
- Writeback to a non-pending register: legal, write performed, pending unchanged.
- Pending bits are registered; a read stalled on pending[x] becomes acceptable the cycle after x's writeback.
- Clear: clear_req sets clear_pend. When state==IDLE and clear_pend is set, the controller moves to CLEAR (no read is accepted that cycle). In CLEAR: rf_reset_enable=1, wb_ready=0, rd_ready=0; pending<=0, clear_pend<=0; state->IDLE; clear_done=1 in the next cycle only. A clear_req arriving during READ/HOLD waits until the return to IDLE.
- Invariant: rf_set_enable and rf_reset_enable are never high together; rf_get_enable is high only in an accept cycle.

Test Plan:
- Reset, write r3=0x5A via wb, then read src1=3 src2=0 -> op_valid 2 cycles after accept with op_a=0x5A, op_b=0x00; rd_ready=0 until op_ready.
- Read with dst_en, dst=2, then read src1=2 -> rd_ready low until the wb to r2 (0x11) is accepted; re-accepted the next cycle, op_a=0x11.
- wb_valid wb_num=4 in the same cycle as rd_valid src2=4 -> rd_ready=0 that cycle; accepted the next cycle with the new value.
- op_ready held low 5 cycles in HOLD -> op_a/op_b stable, no rf_get_enable, wb still accepted and written.
- clear_req during HOLD -> CLEAR entered after op_ready; rf_reset_enable one cycle, clear_done next cycle, pending=0, subsequent reads return 0.
- Reset asserted in READ with pending[5]=1 -> next cycle IDLE, op_valid=0, pending=0, rf_reset_enable never asserted.

Source files
------------

// File: rtl/register_controller_if.sv
// ---------------------------------------------------------------------------
// register_controller_if
// Handshake bundle between the operand-read issuer, the operand consumer,
// the writeback source and register_controller.
//   rd_*  : operand-read request (valid/ready), sources, destination tag
//   op_*  : operand pair return (valid/ready)
//   wb_*  : writeback request (valid/ready), index and data
// Modports:
//   master : the core side (issuer / consumer / writeback source)
//   slave  : register_controller
// ---------------------------------------------------------------------------
interface register_controller_if #(
    parameter int WORD_SIZE = 8,
    parameter int REG_BITS  = 3
);
    logic                 rd_valid;
    logic                 rd_ready;
    logic [REG_BITS-1:0]  rd_src1;
    logic [REG_BITS-1:0]  rd_src2;
    logic [REG_BITS-1:0]  rd_dst;
    logic                 rd_dst_en;

    logic                 op_valid;
    logic                 op_ready;
    logic [WORD_SIZE-1:0] op_a;
    logic [WORD_SIZE-1:0] op_b;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [REG_BITS-1:0]  wb_num;
    logic [WORD_SIZE-1:0] wb_val;

    modport master (
        output rd_valid, rd_src1, rd_src2, rd_dst, rd_dst_en,
        input  rd_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output wb_valid, wb_num, wb_val,
        input  wb_ready
    );

    modport slave (
        input  rd_valid, rd_src1, rd_src2, rd_dst, rd_dst_en,
        output rd_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  wb_valid, wb_num, wb_val,
        output wb_ready
    );
endinterface

// File: rtl/register_controller.sv
// ---------------------------------------------------------------------------
// register_controller
// Sequences every access to the general-purpose register file: operand-pair
// reads through a valid/ready handshake, the single writeback port, and
// whole-file clears. A pending-write scoreboard stalls reads whose sources
// are still in flight (RAW interlock).
// Ports:
//   clock, reset      : core clock, synchronous active-high reset
//   bus (slave)       : rd_* request, op_* operand return, wb_* writeback
//   clear_req         : one-cycle pulse asking for all registers to be zeroed
//   clear_done        : one-cycle pulse after the clear strobe was issued
//   busy              : not idle, or some register still has a pending write
//   rf_num1/rf_num2   : register file read indices
//   rf_get_enable     : register file read strobe (data appears next cycle)
//   rf_set_*          : register file write strobe, index, data
//   rf_reset_enable   : register file clear strobe
//   rf_out1/rf_out2   : registered register file read data
// ---------------------------------------------------------------------------
module register_controller #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_REGS  = 8,
    parameter int REG_BITS  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    register_controller_if.slave bus,
    input  logic                 clear_req,
    output logic                 clear_done,
    output logic                 busy,
    output logic [REG_BITS-1:0]  rf_num1,
    output logic [REG_BITS-1:0]  rf_num2,
    output logic                 rf_get_enable,
    output logic                 rf_set_enable,
    output logic [REG_BITS-1:0]  rf_set_num,
    output logic [WORD_SIZE-1:0] rf_set_val,
    output logic                 rf_reset_enable,
    input  logic [WORD_SIZE-1:0] rf_out1,
    input  logic [WORD_SIZE-1:0] rf_out2
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        CLEAR
    } state_t;

    state_t              state;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic                clear_pend;
    logic                hazard;
    logic                rd_fire;
    logic                wb_fire;

    // A source is blocked if its write is still outstanding, or if the
    // writeback for it is only arriving this cycle: the file has not been
    // updated yet, so reading now would return the stale value.
    assign hazard = pending[bus.rd_src1] | pending[bus.rd_src2]
                  | (bus.wb_valid & ((bus.wb_num == bus.rd_src1) |
                                     (bus.wb_num == bus.rd_src2)));

    assign bus.rd_ready = (state == IDLE) & ~clear_pend & ~clear_req & ~hazard;
    assign bus.wb_ready = (state != CLEAR);

    assign rd_fire = bus.rd_valid & bus.rd_ready;
    assign wb_fire = bus.wb_valid & bus.wb_ready;

    // Strobes are masked during reset so a reset never disturbs the file.
    assign rf_num1         = bus.rd_src1;
    assign rf_num2         = bus.rd_src2;
    assign rf_get_enable   = rd_fire & ~reset;
    assign rf_set_enable   = wb_fire & ~reset;
    assign rf_set_num      = bus.wb_num;
    assign rf_set_val      = bus.wb_val;
    assign rf_reset_enable = (state == CLEAR) & ~reset;

    assign busy = (state != IDLE) | (|pending);

    // Scoreboard update: the set from a read accept is applied after the
    // writeback clear, so a same-cycle accept targeting the register being
    // written leaves it pending for the new producer.
    always_comb begin
        pending_next = pending;
        if (wb_fire) begin
            pending_next[bus.wb_num] = 1'b0;
        end
        if (rd_fire && bus.rd_dst_en) begin
            pending_next[bus.rd_dst] = 1'b1;
        end
        if (state == CLEAR) begin
            pending_next = '0;
        end
    end

    // A clear request that lands while the clear itself executes is kept,
    // so that request is not lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= '0;
            clear_pend   <= 1'b0;
            clear_done   <= 1'b0;
            bus.op_valid <= 1'b0;
            bus.op_a     <= '0;
            bus.op_b     <= '0;
        end else begin
            pending    <= pending_next;
            clear_pend <= clear_req | (clear_pend & (state != CLEAR));
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_pend) begin
                        state <= CLEAR;
                    end else if (rd_fire) begin
                        state <= READ;
                    end
                end
                READ: begin
                    bus.op_a     <= rf_out1;
                    bus.op_b     <= rf_out2;
                    bus.op_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (bus.op_ready) begin
                        bus.op_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                CLEAR: begin
                    clear_done <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_controller.sv
// ---------------------------------------------------------------------------
// tb_register_controller
// Directed bench for register_controller with a behavioural register file
// attached to the rf_* port (registered reads, clear-over-write priority).
// ---------------------------------------------------------------------------
module tb_register_controller;

    logic       clock;
    logic       reset;
    logic       clear_req;
    logic       clear_done;
    logic       busy;
    logic [2:0] rf_num1;
    logic [2:0] rf_num2;
    logic       rf_get_enable;
    logic       rf_set_enable;
    logic [2:0] rf_set_num;
    logic [7:0] rf_set_val;
    logic       rf_reset_enable;
    logic [7:0] rf_out1 = 8'h00;
    logic [7:0] rf_out2 = 8'h00;
    logic [7:0] rf_mem [0:7] = '{default: 8'h00};

    int vectors    = 0;
    int miscompares = 0;

    register_controller_if #(.WORD_SIZE(8), .REG_BITS(3)) bus ();

    register_controller #(.WORD_SIZE(8), .NUM_REGS(8), .REG_BITS(3)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus.slave),
        .clear_req       (clear_req),
        .clear_done      (clear_done),
        .busy            (busy),
        .rf_num1         (rf_num1),
        .rf_num2         (rf_num2),
        .rf_get_enable   (rf_get_enable),
        .rf_set_enable   (rf_set_enable),
        .rf_set_num      (rf_set_num),
        .rf_set_val      (rf_set_val),
        .rf_reset_enable (rf_reset_enable),
        .rf_out1         (rf_out1),
        .rf_out2         (rf_out2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural register file: contents survive reset, read data is
    // registered and shows the value held before any same-edge write.
    always @(posedge clock) begin
        if (rf_reset_enable) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
        end else if (rf_set_enable) begin
            rf_mem[rf_set_num] <= rf_set_val;
        end
        if (rf_get_enable) begin
            rf_out1 <= rf_mem[rf_num1];
            rf_out2 <= rf_mem[rf_num2];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_read(input logic [2:0] s1, input logic [2:0] s2,
                              input logic [2:0] d, input logic en);
        bus.rd_valid  = 1'b1;
        bus.rd_src1   = s1;
        bus.rd_src2   = s2;
        bus.rd_dst    = d;
        bus.rd_dst_en = en;
    endtask

    task automatic drive_wb(input logic [2:0] n, input logic [7:0] v);
        bus.wb_valid = 1'b1;
        bus.wb_num   = n;
        bus.wb_val   = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_wb(3'd1, 8'hFF);
        drive_read(3'd0, 3'd0, 3'd0, 1'b0);
        #2;
        vectors++;
        if (rf_set_enable !== 1'b0 || rf_get_enable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: set=%b get=%b expected 0 0", rf_set_enable, rf_get_enable);
        end
        tick();
        tick();
        vectors++;
        if (bus.op_valid !== 1'b0 || clear_done !== 1'b0 || busy !== 1'b0 || rf_reset_enable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: op_valid=%b clear_done=%b busy=%b rf_reset=%b expected 0 0 0 0",
                     bus.op_valid, clear_done, busy, rf_reset_enable);
        end
        vectors++;
        if (bus.op_a !== 8'h00 || bus.op_b !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_ops: op_a=%h op_b=%h expected 00 00", bus.op_a, bus.op_b);
        end
        reset = 1'b0;
        bus.wb_valid = 1'b0;
        bus.rd_valid = 1'b0;
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b1 || bus.wb_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: rd_ready=%b wb_ready=%b expected 1 1", bus.rd_ready, bus.wb_ready);
        end
    endtask

    task automatic test_basic_read();
        drive_wb(3'd3, 8'h5A);
        #1;
        vectors++;
        if (rf_set_enable !== 1'b1 || rf_set_num !== 3'd3 || rf_set_val !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL basic_wb: set=%b num=%0d val=%h expected 1 3 5a", rf_set_enable, rf_set_num, rf_set_val);
        end
        tick();
        bus.wb_valid = 1'b0;
        drive_read(3'd3, 3'd0, 3'd0, 1'b0);
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b1 || rf_get_enable !== 1'b1 || rf_num1 !== 3'd3 || rf_num2 !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL basic_accept: ready=%b get=%b n1=%0d n2=%0d expected 1 1 3 0",
                     bus.rd_ready, rf_get_enable, rf_num1, rf_num2);
        end
        tick();
        bus.rd_valid = 1'b0;
        #1;
        vectors++;
        if (bus.op_valid !== 1'b0 || bus.rd_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_read_cycle: op_valid=%b rd_ready=%b busy=%b expected 0 0 1",
                     bus.op_valid, bus.rd_ready, busy);
        end
        tick();
        vectors++;
        if (bus.op_valid !== 1'b1 || bus.op_a !== 8'h5A || bus.op_b !== 8'h00 || bus.rd_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_ops: valid=%b a=%h b=%h ready=%b expected 1 5a 00 0",
                     bus.op_valid, bus.op_a, bus.op_b, bus.rd_ready);
        end
        tick();
        vectors++;
        if (bus.op_valid !== 1'b0 || bus.rd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_return_idle: op_valid=%b rd_ready=%b expected 0 1", bus.op_valid, bus.rd_ready);
        end
    endtask

    task automatic test_raw_stall();
        drive_read(3'd0, 3'd0, 3'd2, 1'b1);
        tick();
        bus.rd_valid = 1'b0;
        tick();
        tick();
        drive_read(3'd2, 3'd0, 3'd0, 1'b0);
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL raw_stall: rd_ready=%b busy=%b expected 0 1", bus.rd_ready, busy);
        end
        tick();
        drive_wb(3'd2, 8'h11);
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b0 || bus.wb_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL raw_wb_cycle: rd_ready=%b wb_ready=%b expected 0 1", bus.rd_ready, bus.wb_ready);
        end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL raw_release: rd_ready=%b expected 1", bus.rd_ready);
        end
        tick();
        bus.rd_valid = 1'b0;
        tick();
        vectors++;
        if (bus.op_valid !== 1'b1 || bus.op_a !== 8'h11) begin
            miscompares++;
            $display("[TB] FAIL raw_value: valid=%b a=%h expected 1 11", bus.op_valid, bus.op_a);
        end
        tick();
    endtask

    task automatic test_wb_hazard();
        drive_read(3'd0, 3'd4, 3'd0, 1'b0);
        drive_wb(3'd4, 8'hC3);
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wb_hazard_block: rd_ready=%b expected 0", bus.rd_ready);
        end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wb_hazard_release: rd_ready=%b expected 1", bus.rd_ready);
        end
        tick();
        bus.rd_valid = 1'b0;
        tick();
        vectors++;
        if (bus.op_a !== 8'h00 || bus.op_b !== 8'hC3) begin
            miscompares++;
            $display("[TB] FAIL wb_hazard_value: a=%h b=%h expected 00 c3", bus.op_a, bus.op_b);
        end
        tick();
    endtask

    task automatic test_hold_stall();
        bus.op_ready = 1'b0;
        drive_read(3'd3, 3'd4, 3'd0, 1'b0);
        tick();
        bus.rd_valid = 1'b0;
        tick();
        drive_read(3'd1, 3'd1, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) drive_wb(3'd6, 8'h77);
            else        bus.wb_valid = 1'b0;
            #1;
            vectors++;
            if (bus.op_valid !== 1'b1 || bus.op_a !== 8'h5A || bus.op_b !== 8'hC3 ||
                rf_get_enable !== 1'b0 || bus.rd_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold_stable[%0d]: valid=%b a=%h b=%h get=%b ready=%b expected 1 5a c3 0 0",
                         i, bus.op_valid, bus.op_a, bus.op_b, rf_get_enable, bus.rd_ready);
            end
            if (i == 1) begin
                vectors++;
                if (bus.wb_ready !== 1'b1 || rf_set_enable !== 1'b1 || rf_set_num !== 3'd6) begin
                    miscompares++;
                    $display("[TB] FAIL hold_wb: ready=%b set=%b num=%0d expected 1 1 6",
                             bus.wb_ready, rf_set_enable, rf_set_num);
                end
            end
            tick();
        end
        bus.rd_valid = 1'b0;
        bus.op_ready = 1'b1;
        tick();
        drive_read(3'd6, 3'd3, 3'd0, 1'b0);
        tick();
        bus.rd_valid = 1'b0;
        tick();
        vectors++;
        if (bus.op_a !== 8'h77 || bus.op_b !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL hold_wb_value: a=%h b=%h expected 77 5a", bus.op_a, bus.op_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_read(3'd0, 3'd0, 3'd7, 1'b1);
        drive_wb(3'd7, 8'h42);
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b1 || rf_get_enable !== 1'b1 || rf_set_enable !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_accept: ready=%b get=%b set=%b expected 1 1 1",
                     bus.rd_ready, rf_get_enable, rf_set_enable);
        end
        tick();
        bus.rd_valid = 1'b0;
        bus.wb_valid = 1'b0;
        tick();
        drive_read(3'd7, 3'd0, 3'd0, 1'b0);
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_hold: rd_ready=%b expected 0", bus.rd_ready);
        end
        tick();
        vectors++;
        if (bus.rd_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pending_set_wins: rd_ready=%b busy=%b expected 0 1", bus.rd_ready, busy);
        end
        drive_wb(3'd7, 8'h43);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pending_release: rd_ready=%b expected 1", bus.rd_ready);
        end
        tick();
        bus.rd_valid = 1'b0;
        tick();
        vectors++;
        if (bus.op_a !== 8'h43) begin
            miscompares++;
            $display("[TB] FAIL pending_value: a=%h expected 43", bus.op_a);
        end
        tick();
    endtask

    task automatic test_reset_in_read();
        drive_wb(3'd1, 8'hA5);
        tick();
        bus.wb_valid = 1'b0;
        drive_read(3'd1, 3'd1, 3'd5, 1'b1);
        tick();
        bus.rd_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if (rf_reset_enable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_read_strobe: rf_reset=%b expected 0", rf_reset_enable);
        end
        tick();
        reset = 1'b0;
        drive_read(3'd5, 3'd1, 3'd0, 1'b0);
        #1;
        vectors++;
        if (bus.op_valid !== 1'b0 || busy !== 1'b0 || rf_reset_enable !== 1'b0 || bus.rd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_read_state: valid=%b busy=%b rf_reset=%b ready=%b expected 0 0 0 1",
                     bus.op_valid, busy, rf_reset_enable, bus.rd_ready);
        end
        tick();
        bus.rd_valid = 1'b0;
        tick();
        vectors++;
        if (bus.op_a !== 8'h00 || bus.op_b !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL reset_keeps_file: a=%h b=%h expected 00 a5", bus.op_a, bus.op_b);
        end
        tick();
    endtask

    task automatic test_clear_in_hold();
        bus.op_ready = 1'b0;
        drive_read(3'd2, 3'd6, 3'd5, 1'b1);
        tick();
        bus.rd_valid = 1'b0;
        tick();
        clear_req = 1'b1;
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b0 || rf_reset_enable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_req_hold: ready=%b rf_reset=%b expected 0 0", bus.rd_ready, rf_reset_enable);
        end
        tick();
        clear_req = 1'b0;
        #1;
        vectors++;
        if (bus.op_valid !== 1'b1 || rf_reset_enable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_waits: valid=%b rf_reset=%b expected 1 0", bus.op_valid, rf_reset_enable);
        end
        bus.op_ready = 1'b1;
        tick();
        drive_read(3'd2, 3'd6, 3'd0, 1'b0);
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b0 || rf_get_enable !== 1'b0 || busy !== 1'b1 || rf_reset_enable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_pending_idle: ready=%b get=%b busy=%b rf_reset=%b expected 0 0 1 0",
                     bus.rd_ready, rf_get_enable, busy, rf_reset_enable);
        end
        tick();
        vectors++;
        if (rf_reset_enable !== 1'b1 || bus.wb_ready !== 1'b0 || bus.rd_ready !== 1'b0 || clear_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_cycle: rf_reset=%b wb_ready=%b rd_ready=%b done=%b expected 1 0 0 0",
                     rf_reset_enable, bus.wb_ready, bus.rd_ready, clear_done);
        end
        tick();
        vectors++;
        if (clear_done !== 1'b1 || rf_reset_enable !== 1'b0 || busy !== 1'b0 || bus.rd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clear_done: done=%b rf_reset=%b busy=%b ready=%b expected 1 0 0 1",
                     clear_done, rf_reset_enable, busy, bus.rd_ready);
        end
        tick();
        bus.rd_valid = 1'b0;
        #1;
        vectors++;
        if (clear_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_done_pulse: done=%b expected 0", clear_done);
        end
        tick();
        vectors++;
        if (bus.op_a !== 8'h00 || bus.op_b !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL clear_values: a=%h b=%h expected 00 00", bus.op_a, bus.op_b);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        clear_req     = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_src1   = 3'd0;
        bus.rd_src2   = 3'd0;
        bus.rd_dst    = 3'd0;
        bus.rd_dst_en = 1'b0;
        bus.op_ready  = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_num    = 3'd0;
        bus.wb_val    = 8'h00;

        test_reset();
        test_basic_read();
        test_raw_stall();
        test_wb_hazard();
        test_hold_stall();
        test_back_to_back();
        test_reset_in_read();
        test_clear_in_hold();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
